// File: rtl/light_part_pkg.sv
// rtl/light_part_pkg.sv - shared op encoding, FSM states and default sizing for the light-part sketch
package light_part_pkg;

    localparam int KEY_W_DEF    = 96;
    localparam int ROWS_DEF     = 8;
    localparam int INDEX_W_DEF  = 16;
    localparam int CNT_W_DEF    = 8;
    localparam int INC_W_DEF    = 8;
    localparam int HASH_ROT_DEF = 7;

    typedef enum logic {
        OP_UPDATE = 1'b0,
        OP_QUERY  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWEEP
    } state_e;

endpackage

// File: rtl/light_hash_fold.sv
// rtl/light_hash_fold.sv - rotate the flow key left by ROT bits and XOR-fold it down to a row index
module light_hash_fold #(
    parameter int KEY_W   = 96,
    parameter int INDEX_W = 16,
    parameter int ROT     = 0
) (
    input  logic [KEY_W-1:0]   key,
    output logic [INDEX_W-1:0] idx
);

    localparam int R      = ROT % KEY_W;
    localparam int CHUNKS = KEY_W / INDEX_W;

    logic [KEY_W-1:0] rotated;

    generate
        if (R == 0) begin : g_norot
            assign rotated = key;
        end else begin : g_rot
            assign rotated = (key << R) | (key >> (KEY_W - R));
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            idx = idx ^ rotated[i*INDEX_W +: INDEX_W];
        end
    end

endmodule

// File: rtl/light_part_cms.sv
// rtl/light_part_cms.sv - ROWS x 2^INDEX_W saturating count-min sketch with 2-stage RMW pipeline and clear sweep
module light_part_cms
    import light_part_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int INC_W    = INC_W_DEF,
    parameter int HASH_ROT = HASH_ROT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ip_addr_light_in_wr,
    input  logic [KEY_W-1:0]   ip_addr_light_in,
    input  logic               ip_addr_light_in_op,
    input  logic [INC_W-1:0]   ip_addr_light_in_inc,
    output logic               ip_addr_light_in_alf,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               ip_addr_light_out_wr,
    output logic [KEY_W-1:0]   ip_addr_light_out,
    output logic               ip_addr_light_out_op,
    output logic [CNT_W-1:0]   ip_addr_light_out_cnt,
    input  logic               ip_addr_light_out_alf,
    output logic [15:0]        drop_cnt
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e state, state_nxt;
    logic [INDEX_W-1:0] sweep_idx;
    logic               sweeping;
    logic               sweep_last;
    logic               accept;

    logic [ROWS-1:0][INDEX_W-1:0] idx_s0;
    logic                         s1_valid;
    logic [KEY_W-1:0]             s1_key;
    op_e                          s1_op;
    logic [INC_W-1:0]             s1_inc;
    logic [ROWS-1:0][INDEX_W-1:0] s1_idx;
    logic [ROWS-1:0][CNT_W-1:0]   n_row;
    logic [CNT_W-1:0]             row_min;
    logic                         ram_wen;

    logic                         fwd_valid;
    logic [ROWS-1:0][INDEX_W-1:0] fwd_idx;
    logic [ROWS-1:0][CNT_W-1:0]   fwd_val;

    assign sweeping   = (state == ST_SWEEP);
    assign sweep_last = (sweep_idx == '1);
    assign accept     = ip_addr_light_in_wr && (state == ST_IDLE);
    assign ram_wen    = sweeping || (s1_valid && (s1_op == OP_UPDATE));

    assign ip_addr_light_in_alf = ip_addr_light_out_alf || (state != ST_IDLE) || clr_start;
    // Busy also covers the done cycle so software sees one continuous window.
    assign clr_busy = (state != ST_IDLE) || clr_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_SWEEP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clr_start) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_SWEEP;
            ST_SWEEP: if (sweep_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_idx <= '0;
            clr_done  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            sweep_idx <= sweeping ? sweep_idx + INDEX_W'(1) : '0;
            clr_done  <= sweeping && sweep_last;
            if (ip_addr_light_in_wr && !accept && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            logic [CNT_W-1:0]   mem [DEPTH];
            logic [CNT_W-1:0]   q_r;
            logic [CNT_W-1:0]   v_r;
            logic [SUM_W-1:0]   sum_r;
            logic [INDEX_W-1:0] waddr_r;
            logic [CNT_W-1:0]   wdata_r;

            light_hash_fold #(
                .KEY_W   (KEY_W),
                .INDEX_W (INDEX_W),
                .ROT     ((r * HASH_ROT) % KEY_W)
            ) u_hash (
                .key (ip_addr_light_in),
                .idx (idx_s0[r])
            );

            assign waddr_r = sweeping ? sweep_idx : s1_idx[r];
            assign wdata_r = sweeping ? '0 : n_row[r];

            // Read returns pre-write contents on a same-edge collision; forwarding covers that case.
            always_ff @(posedge clk) begin
                if (ram_wen) begin
                    mem[waddr_r] <= wdata_r;
                end
                if (accept) begin
                    q_r <= mem[idx_s0[r]];
                end
            end

            assign v_r   = (fwd_valid && (fwd_idx[r] == s1_idx[r])) ? fwd_val[r] : q_r;
            assign sum_r = SUM_W'(v_r) + SUM_W'(s1_inc);
            assign n_row[r] = (s1_op == OP_QUERY) ? v_r :
                              (sum_r > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_r[CNT_W-1:0];
        end
    endgenerate

    always_comb begin
        row_min = CNT_MAX;
        for (int r = 0; r < ROWS; r++) begin
            if (n_row[r] < row_min) begin
                row_min = n_row[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_key   <= '0;
            s1_op    <= OP_UPDATE;
            s1_inc   <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_key <= ip_addr_light_in;
                s1_op  <= op_e'(ip_addr_light_in_op);
                s1_inc <= ip_addr_light_in_inc;
                s1_idx <= idx_s0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_valid <= 1'b0;
            fwd_idx   <= '0;
            fwd_val   <= '0;
        end else begin
            fwd_valid <= !sweeping && s1_valid && (s1_op == OP_UPDATE);
            if (s1_valid) begin
                fwd_idx <= s1_idx;
                fwd_val <= n_row;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ip_addr_light_out_wr  <= 1'b0;
            ip_addr_light_out     <= '0;
            ip_addr_light_out_op  <= 1'b0;
            ip_addr_light_out_cnt <= '0;
        end else begin
            ip_addr_light_out_wr <= s1_valid;
            if (s1_valid) begin
                ip_addr_light_out     <= s1_key;
                ip_addr_light_out_op  <= s1_op;
                ip_addr_light_out_cnt <= row_min;
            end
        end
    end

endmodule

// File: tb/tb_light_part_cms.sv
// tb/tb_light_part_cms.sv - self-checking bench for light_part_cms against a count-min array model
module tb_light_part_cms;

    localparam int KW = 96;
    localparam int NR = 4;
    localparam int IW = 6;

    logic          clk;
    logic          reset;
    logic          in_wr;
    logic [KW-1:0] in_key;
    logic          in_op;
    logic [7:0]    in_inc;
    logic          in_alf;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          out_wr;
    logic [KW-1:0] out_key;
    logic          out_op;
    logic [7:0]    out_cnt;
    logic          out_alf;
    logic [15:0]   drop_cnt;

    light_part_cms #(
        .KEY_W(KW), .ROWS(NR), .INDEX_W(IW), .CNT_W(8), .INC_W(8), .HASH_ROT(7)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ip_addr_light_in_wr   (in_wr),
        .ip_addr_light_in      (in_key),
        .ip_addr_light_in_op   (in_op),
        .ip_addr_light_in_inc  (in_inc),
        .ip_addr_light_in_alf  (in_alf),
        .clr_start             (clr_start),
        .clr_busy              (clr_busy),
        .clr_done              (clr_done),
        .ip_addr_light_out_wr  (out_wr),
        .ip_addr_light_out     (out_key),
        .ip_addr_light_out_op  (out_op),
        .ip_addr_light_out_cnt (out_cnt),
        .ip_addr_light_out_alf (out_alf),
        .drop_cnt              (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [KW-1:0] key;
        logic          op;
        logic [7:0]    cnt;
        int            due;
    } exp_t;

    exp_t       exp_q[$];
    int         model [NR][1<<IW];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [7:0] last_cnt = 8'hxx;
    logic [KW-1:0] pool [6];
    logic [KW-1:0] k1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int hidx(input logic [KW-1:0] k, input int r);
        int s;
        int h;
        logic [KW-1:0] rk;
        s  = (r * 7) % KW;
        rk = (s == 0) ? k : ((k << s) | (k >> (KW - s)));
        h  = 0;
        for (int i = 0; i < KW / IW; i++) begin
            h  = h ^ int'(rk[IW-1:0]);
            rk = rk >> IW;
        end
        return h;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < (1 << IW); i++)
                model[r][i] = 0;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("out_wr", out_wr, 1);
            check("out_key", out_key, e.key);
            check("out_op", out_op, e.op);
            check("out_cnt", out_cnt, e.cnt);
            last_cnt = out_cnt;
        end else begin
            check("out_wr_idle", out_wr, 0);
        end
    endtask

    task automatic issue(input logic [KW-1:0] k, input logic op, input logic [7:0] inc, input bit acc);
        exp_t e;
        int v;
        int nv;
        int mn;
        in_wr  = 1'b1;
        in_key = k;
        in_op  = op;
        in_inc = inc;
        if (acc) begin
            mn = 255;
            for (int r = 0; r < NR; r++) begin
                v  = model[r][hidx(k, r)];
                nv = op ? v : ((v + int'(inc) > 255) ? 255 : v + int'(inc));
                model[r][hidx(k, r)] = nv;
                if (nv < mn) mn = nv;
            end
            e.key = k;
            e.op  = op;
            e.cnt = 8'(mn);
            e.due = cyc + 2;
            exp_q.push_back(e);
        end
        tick();
        in_wr = 1'b0;
    endtask

    task automatic wait_sweep(input string tag, input int exp_busy);
        int busy;
        int dn;
        int n;
        busy = 0;
        dn   = 0;
        n    = 0;
        while (clr_busy && n < 300) begin
            busy++;
            if (clr_done) dn++;
            tick();
            n++;
        end
        if (exp_busy >= 0) check({tag, "_busy_cycles"}, busy, exp_busy);
        check({tag, "_done_pulses"}, dn, 1);
        check({tag, "_busy_cleared"}, clr_busy, 0);
        model_clear();
    endtask

    initial begin
        reset = 1'b0; in_wr = 1'b0; in_key = '0; in_op = 1'b0; in_inc = '0;
        clr_start = 1'b0; out_alf = 1'b0;
        model_clear();
        repeat (3) tick();
        check("rst_out_wr", out_wr, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_out_key", out_key, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_clr_busy", clr_busy, 1);
        check("rst_clr_done", clr_done, 0);
        check("rst_in_alf", in_alf, 1);
        reset = 1'b1;
        wait_sweep("boot", 65);

        issue(96'h1234, 1'b1, 8'd0, 1);
        repeat (2) tick();
        check("boot_query", last_cnt, 0);

        for (int i = 0; i < 3; i++) issue(96'h1234, 1'b0, 8'd1, 1);
        repeat (2) tick();
        check("fwd_third", last_cnt, 3);

        issue(96'hABCD_0000_5A5A_0000_0000_7777, 1'b0, 8'd200, 1);
        issue(96'hABCD_0000_5A5A_0000_0000_7777, 1'b0, 8'd200, 1);
        issue(96'hABCD_0000_5A5A_0000_0000_7777, 1'b1, 8'd9, 1);
        repeat (2) tick();
        check("sat_query", last_cnt, 255);

        clr_start = 1'b1;
        #1;
        check("clr_in_alf", in_alf, 1);
        issue(96'h1234, 1'b0, 8'd2, 1);
        clr_start = 1'b0;
        model_clear();
        tick();
        check("sweep_in_alf", in_alf, 1);
        issue(96'h1234, 1'b0, 8'd7, 0);
        check("drop_one", drop_cnt, 1);
        wait_sweep("clr", 64);
        issue(96'h1234, 1'b1, 8'd0, 1);
        repeat (2) tick();
        check("post_clr_query", last_cnt, 0);

        k1 = 96'h0F0F_1111_2222_3333_4444_5555;
        issue(k1, 1'b0, 8'd5, 1);
        issue(k1 ^ 96'h41, 1'b0, 8'd3, 1);
        issue(k1, 1'b1, 8'd0, 1);
        repeat (2) tick();
        check("collision", last_cnt, 8);

        out_alf = 1'b1;
        #1;
        check("alf_pass", in_alf, 1);
        issue(k1, 1'b1, 8'd0, 1);
        out_alf = 1'b0;
        #1;
        check("alf_clear", in_alf, 0);

        for (int i = 0; i < 5; i++) pool[i] = {$urandom, $urandom, $urandom};
        pool[5] = pool[4] ^ 96'h41;
        for (int i = 0; i < 300; i++) begin
            out_alf = 1'($urandom_range(0, 1));
            #1;
            check("rand_in_alf", in_alf, out_alf);
            if ($urandom_range(0, 3) == 0) tick();
            else issue(pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 40)), 1);
        end
        out_alf = 1'b0;
        repeat (3) tick();

        issue(k1, 1'b0, 8'd9, 0);
        reset = 1'b0;
        repeat (3) tick();
        check("mid_op_drop_cnt", drop_cnt, 0);
        check("mid_op_busy", clr_busy, 1);
        reset = 1'b1;
        repeat (30) tick();
        reset = 1'b0;
        tick();
        check("mid_sweep_busy", clr_busy, 1);
        check("mid_sweep_done", clr_done, 0);
        reset = 1'b1;
        wait_sweep("restart", 65);
        issue(k1, 1'b1, 8'd0, 1);
        repeat (3) tick();
        check("restart_query", last_cnt, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
